// File: rtl/systolic_tile_engine.sv
// Output-stationary SA_N x SA_N systolic tile: C = (A + in_offset) x B over
// k_len K-slices, one operand beat in per cycle, one result row out per beat.
// Ports: start/k_len/acc_clr/in_offset set up a job (sampled in IDLE);
//   in_valid/in_ready + a_col/b_row carry one K-slice per beat (lane 0 MSBs);
//   c_valid/c_ready + c_row/c_row_idx return one C row per beat;
//   busy/done/state_o report progress (IDLE=0 LOAD=1 DRAIN=2 OUT=3).
module systolic_tile_engine #(
   parameter int SA_N   = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int K_W    = 16,
   parameter int OFF_W  = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [K_W-1:0]          k_len,
   input  logic                    acc_clr,
   input  logic [OFF_W-1:0]        in_offset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SA_N*DATA_W-1:0]  a_col,
   input  logic [SA_N*DATA_W-1:0]  b_row,
   output logic                    c_valid,
   input  logic                    c_ready,
   output logic [SA_N*ACC_W-1:0]   c_row,
   output logic [$clog2(SA_N)-1:0] c_row_idx,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              state_o
);

   localparam int RW = $clog2(SA_N);
   localparam int SW = ((DATA_W > OFF_W) ? DATA_W : OFF_W) + 1;
   localparam int PW = SW + DATA_W;
   localparam int DW = $clog2(2 * SA_N);
   localparam int L  = 2 * SA_N - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [K_W-1:0]   klen_q, klen_d;
   logic [K_W-1:0]   cnt_q, cnt_d;
   logic [OFF_W-1:0] off_q, off_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic [RW-1:0]    r_q, r_d;
   logic             done_q, done_d;
   logic             accept, clr_now;

   // Per-row (A) and per-column (B) shift lines. A lane i is injected at
   // position SA_N-1-i, so it reaches position SA_N-1+j (PE column j) after
   // i+j cycles; B mirrors this, which lines up A[i][k] with B[k][j].
   logic [DATA_W-1:0] ash_q [SA_N][L];
   logic [DATA_W-1:0] ash_d [SA_N][L];
   logic [DATA_W-1:0] bsh_q [SA_N][L];
   logic [DATA_W-1:0] bsh_d [SA_N][L];
   logic [ACC_W-1:0]  acc_q [SA_N][SA_N];
   logic [ACC_W-1:0]  acc_d [SA_N][SA_N];

   function automatic logic [ACC_W-1:0] mac(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [OFF_W-1:0]  o
   );
      logic signed [SW-1:0] s;
      logic signed [PW-1:0] p;
      s = SW'($signed(a)) + SW'($signed(o));
      p = PW'(s) * PW'($signed(b));
      return ACC_W'(p);
   endfunction

   assign accept  = in_valid & (state_q == LOAD);
   assign clr_now = (state_q == IDLE) & start & acc_clr;

   always_comb begin
      state_d = state_q;
      klen_d  = klen_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      dcnt_d  = dcnt_q;
      r_d     = r_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               klen_d  = k_len;
               off_d   = in_offset;
               cnt_d   = '0;
               dcnt_d  = '0;
               r_d     = '0;
               state_d = (k_len == '0) ? DRAIN : LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + K_W'(1);
               if (cnt_q == klen_q - K_W'(1)) begin
                  state_d = DRAIN;
                  dcnt_d  = '0;
               end
            end
         end
         DRAIN: begin
            if (dcnt_q == DW'(2 * SA_N - 1)) begin
               state_d = OUT;
               r_d     = '0;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         OUT: begin
            if (c_ready) begin
               if (r_q == RW'(SA_N - 1)) begin
                  state_d = IDLE;
                  r_d     = '0;
                  done_d  = 1'b1;
               end else begin
                  r_d = r_q + RW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Cycles without an accepted beat inject zeros on both A and B, so the
   // product is zero whatever the offset.
   always_comb begin
      for (int i = 0; i < SA_N; i++) begin
         ash_d[i][0] = '0;
         bsh_d[i][0] = '0;
         for (int p = 1; p < L; p++) begin
            ash_d[i][p] = ash_q[i][p-1];
            bsh_d[i][p] = bsh_q[i][p-1];
         end
         ash_d[i][SA_N-1-i] = accept ?
            a_col[(SA_N-1-i)*DATA_W +: DATA_W] : '0;
         bsh_d[i][SA_N-1-i] = accept ?
            b_row[(SA_N-1-i)*DATA_W +: DATA_W] : '0;
      end
   end

   always_comb begin
      for (int i = 0; i < SA_N; i++) begin
         for (int j = 0; j < SA_N; j++) begin
            acc_d[i][j] = clr_now ? '0 :
               acc_q[i][j] + mac(ash_q[i][SA_N-1+j],
                                 bsh_q[j][SA_N-1+i], off_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         klen_q  <= '0;
         cnt_q   <= '0;
         off_q   <= '0;
         dcnt_q  <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < SA_N; i++) begin
            for (int p = 0; p < L; p++) begin
               ash_q[i][p] <= '0;
               bsh_q[i][p] <= '0;
            end
            for (int j = 0; j < SA_N; j++) begin
               acc_q[i][j] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         klen_q  <= klen_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         dcnt_q  <= dcnt_d;
         r_q     <= r_d;
         done_q  <= done_d;
         for (int i = 0; i < SA_N; i++) begin
            for (int p = 0; p < L; p++) begin
               ash_q[i][p] <= ash_d[i][p];
               bsh_q[i][p] <= bsh_d[i][p];
            end
            for (int j = 0; j < SA_N; j++) begin
               acc_q[i][j] <= acc_d[i][j];
            end
         end
      end
   end

   always_comb begin
      c_row = '0;
      if (state_q == OUT) begin
         for (int j = 0; j < SA_N; j++) begin
            c_row[(SA_N-1-j)*ACC_W +: ACC_W] = acc_q[r_q][j];
         end
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign c_valid   = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign state_o   = state_q;
   assign c_row_idx = r_q;

endmodule
